// File: rtl/branch_resolve_if.sv
// Execute/fetch-facing bundle for branch_resolve_unit. Signal names keep the
// original port names so existing hookups map one-to-one.
interface branch_resolve_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            ex_valid_i;
  logic            ex_stall_i;
  logic [6:0]      opcode_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] src_a_i;
  logic [XLEN-1:0] src_b_i;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] imm_i;
  logic            pred_taken_i;
  logic [XLEN-1:0] pred_target_i;
  logic [XLEN-1:0] lookup_pc_i;
  logic            lookup_taken_o;
  logic            flush_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            br_taken_o;
  logic            resolve_valid_o;

  modport master (
    output ex_valid_i, ex_stall_i, opcode_i, funct3_i, src_a_i, src_b_i,
           pc_i, imm_i, pred_taken_i, pred_target_i, lookup_pc_i,
    input  lookup_taken_o, flush_o, redirect_pc_o, br_taken_o, resolve_valid_o
  );

  modport slave (
    input  ex_valid_i, ex_stall_i, opcode_i, funct3_i, src_a_i, src_b_i,
           pc_i, imm_i, pred_taken_i, pred_target_i, lookup_pc_i,
    output lookup_taken_o, flush_o, redirect_pc_o, br_taken_o, resolve_valid_o
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: evaluates B-type/JAL/JALR, flags mispredicts
// one cycle later, and trains a direct-mapped BHT of 2-bit counters.
module branch_resolve_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  localparam int unsigned BHT_IDX_W  = $clog2(BHT_ENTRIES)
) (
  input  logic clk,
  input  logic rst_n,
  branch_resolve_if.slave bus
);

  typedef enum logic [6:0] {
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111
  } opcode_e;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_e;

  logic                 is_branch;
  logic                 is_jal;
  logic                 is_jalr;
  logic                 fire;

  logic [XLEN:0]        diff;
  logic                 cmp_eq;
  logic                 cmp_lt;
  logic                 cmp_ltu;
  logic                 sub_ovf;
  logic                 cond_taken;
  logic                 taken;

  logic [XLEN-1:0]      pc_rel_sum;
  logic [XLEN-1:0]      jalr_sum;
  logic [XLEN-1:0]      target;
  logic [XLEN-1:0]      seq_pc;
  logic [XLEN-1:0]      next_pc;
  logic                 mispredict;

  logic [BHT_IDX_W-1:0] upd_idx;
  logic [BHT_IDX_W-1:0] lkp_idx;
  logic                 bht_we;
  logic [1:0]           bht_cur;
  logic [1:0]           bht_d;
  logic [1:0]           bht_q [BHT_ENTRIES];

  logic                 flush_q,         flush_d;
  logic                 br_taken_q,      br_taken_d;
  logic                 resolve_valid_q, resolve_valid_d;
  logic [XLEN-1:0]      redirect_pc_q,   redirect_pc_d;

  logic                 unused_bits;

  // Decode and fire qualification
  always_comb begin
    is_branch = (bus.opcode_i == OP_BRANCH);
    is_jal    = (bus.opcode_i == OP_JAL);
    is_jalr   = (bus.opcode_i == OP_JALR);
    fire      = bus.ex_valid_i & ~bus.ex_stall_i & (is_branch | is_jal | is_jalr);
  end

  // One shared XLEN+1 subtract feeds all three comparisons; bit XLEN is the borrow.
  always_comb begin
    diff    = {1'b0, bus.src_a_i} - {1'b0, bus.src_b_i};
    cmp_eq  = (diff[XLEN-1:0] == '0);
    sub_ovf = (bus.src_a_i[XLEN-1] ^ bus.src_b_i[XLEN-1])
            & (diff[XLEN-1] ^ bus.src_a_i[XLEN-1]);
    cmp_lt  = diff[XLEN-1] ^ sub_ovf;
    cmp_ltu = diff[XLEN];
  end

  always_comb begin
    cond_taken = 1'b0;
    case (bus.funct3_i)
      F3_BEQ:  cond_taken = cmp_eq;
      F3_BNE:  cond_taken = ~cmp_eq;
      F3_BLT:  cond_taken = cmp_lt;
      F3_BGE:  cond_taken = ~cmp_lt;
      F3_BLTU: cond_taken = cmp_ltu;
      F3_BGEU: cond_taken = ~cmp_ltu;
      default: cond_taken = 1'b0;
    endcase
    taken = (is_jal | is_jalr) ? 1'b1 : cond_taken;
  end

  // Targets and mispredict detection
  always_comb begin
    pc_rel_sum = bus.pc_i + bus.imm_i;
    jalr_sum   = bus.src_a_i + bus.imm_i;
    target     = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc_rel_sum;
    seq_pc     = bus.pc_i + XLEN'(4);
    next_pc    = taken ? target : seq_pc;
    mispredict = (taken != bus.pred_taken_i)
               | (taken & bus.pred_taken_i & (target != bus.pred_target_i));
  end

  // BHT training; counters saturate at 00 and 11
  always_comb begin
    upd_idx = bus.pc_i[BHT_IDX_W+1:2];
    lkp_idx = bus.lookup_pc_i[BHT_IDX_W+1:2];
    bht_we  = fire & is_branch;
    bht_cur = bht_q[upd_idx];
    bht_d   = bht_cur;
    if (taken) begin
      if (bht_cur != 2'b11) bht_d = bht_cur + 2'd1;
    end else begin
      if (bht_cur != 2'b00) bht_d = bht_cur - 2'd1;
    end
  end

  // Registered result next-state
  always_comb begin
    resolve_valid_d = fire;
    br_taken_d      = fire & taken;
    flush_d         = fire & mispredict;
    redirect_pc_d   = fire ? next_pc : redirect_pc_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resolve_valid_q <= 1'b0;
      br_taken_q      <= 1'b0;
      flush_q         <= 1'b0;
      redirect_pc_q   <= '0;
    end else begin
      resolve_valid_q <= resolve_valid_d;
      br_taken_q      <= br_taken_d;
      flush_q         <= flush_d;
      redirect_pc_q   <= redirect_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bht_q <= '{default: 2'b01};
    end else if (bht_we) begin
      bht_q[upd_idx] <= bht_d;
    end
  end

  // Lookup reads the array directly, so a same-cycle write is not forwarded.
  always_comb begin
    bus.lookup_taken_o  = bht_q[lkp_idx][1];
    bus.flush_o         = flush_q;
    bus.br_taken_o      = br_taken_q;
    bus.resolve_valid_o = resolve_valid_q;
    bus.redirect_pc_o   = redirect_pc_q;
  end

  assign unused_bits = ^{bus.pc_i[XLEN-1:BHT_IDX_W+2], bus.pc_i[1:0],
                         bus.lookup_pc_i[XLEN-1:BHT_IDX_W+2], bus.lookup_pc_i[1:0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit at XLEN=32/64 entries and XLEN=64/16 entries,
// compared against an arithmetic reference model.
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_resolve_if #(.XLEN(32)) bus32 ();
  branch_resolve_if #(.XLEN(64)) bus64 ();

  branch_resolve_unit #(.XLEN(32), .BHT_ENTRIES(64)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(bus32)
  );
  branch_resolve_unit #(.XLEN(64), .BHT_ENTRIES(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .bus(bus64)
  );

  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] ALU  = 7'b0110011;

  int checks   = 0;
  int failures = 0;

  int unsigned    m_bht [2][64];
  bit             m_rv  [2];
  bit             m_bt  [2];
  bit             m_fl  [2];
  logic [63:0]    m_rpc [2];
  bit             m_known = 1'b0;
  int unsigned    m_ent [2] = '{64, 16};
  int unsigned    m_w   [2] = '{32, 64};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wmask(input int unsigned w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic bit ref_taken(input int unsigned w, input logic [6:0] opc,
                                   input logic [2:0] f3, input logic [63:0] a, b);
    logic [63:0] ua = a << (64 - w);
    logic [63:0] ub = b << (64 - w);
    if (opc == JAL || opc == JALR) return 1'b1;
    case (f3)
      3'd0: return ua == ub;
      3'd1: return ua != ub;
      3'd4: return $signed(ua) <  $signed(ub);
      3'd5: return $signed(ua) >= $signed(ub);
      3'd6: return ua <  ub;
      3'd7: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input int k, input bit rst, input bit valid, input bit stall,
                      input logic [6:0] opc, input logic [2:0] f3,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] pc, input logic [63:0] imm,
                      input bit pt, input logic [63:0] ptgt,
                      input logic [63:0] lpc, input string tag);
    logic [63:0] mk, tgt, nxt, obs_rpc;
    bit tk, mis, fire, obs_lk, obs_rv, obs_bt, obs_fl;
    int unsigned li, ui;
    @(negedge clk);
    rst_n = ~rst;
    bus32.ex_valid_i    = (k == 0) && valid;
    bus64.ex_valid_i    = (k == 1) && valid;
    bus32.ex_stall_i    = stall;  bus64.ex_stall_i    = stall;
    bus32.opcode_i      = opc;    bus64.opcode_i      = opc;
    bus32.funct3_i      = f3;     bus64.funct3_i      = f3;
    bus32.src_a_i       = a[31:0];    bus64.src_a_i       = a;
    bus32.src_b_i       = b[31:0];    bus64.src_b_i       = b;
    bus32.pc_i          = pc[31:0];   bus64.pc_i          = pc;
    bus32.imm_i         = imm[31:0];  bus64.imm_i         = imm;
    bus32.pred_taken_i  = pt;     bus64.pred_taken_i  = pt;
    bus32.pred_target_i = ptgt[31:0]; bus64.pred_target_i = ptgt;
    bus32.lookup_pc_i   = lpc[31:0];  bus64.lookup_pc_i   = lpc;
    #1;
    li = int'((lpc >> 2) % m_ent[k]);
    if (m_known) begin
      obs_lk = (k == 0) ? bus32.lookup_taken_o : bus64.lookup_taken_o;
      check({tag, ".lookup"}, 64'(obs_lk), 64'(m_bht[k][li] >= 2));
    end

    for (int j = 0; j < 2; j++) begin
      mk   = wmask(m_w[j]);
      tk   = ref_taken(m_w[j], opc, f3, a, b);
      tgt  = (opc == JALR) ? (((a + imm) & mk) & ~64'd1) : ((pc + imm) & mk);
      nxt  = tk ? tgt : ((pc + 64'd4) & mk);
      mis  = (tk != pt) || (tk && pt && (tgt != (ptgt & mk)));
      fire = (j == k) && valid && !stall && (opc == BR || opc == JAL || opc == JALR);
      if (rst) begin
        m_rv[j] = 0; m_bt[j] = 0; m_fl[j] = 0; m_rpc[j] = '0;
        for (int e = 0; e < 64; e++) m_bht[j][e] = 1;
      end else begin
        m_rv[j] = fire;
        m_bt[j] = fire && tk;
        m_fl[j] = fire && mis;
        if (fire) m_rpc[j] = nxt;
        if (fire && opc == BR) begin
          ui = int'((pc >> 2) % m_ent[j]);
          if (tk && m_bht[j][ui] < 3) m_bht[j][ui]++;
          if (!tk && m_bht[j][ui] > 0) m_bht[j][ui]--;
        end
      end
    end
    if (rst) m_known = 1'b1;

    @(posedge clk);
    #1;
    if (m_known) begin
      obs_rv  = (k == 0) ? bus32.resolve_valid_o : bus64.resolve_valid_o;
      obs_bt  = (k == 0) ? bus32.br_taken_o      : bus64.br_taken_o;
      obs_fl  = (k == 0) ? bus32.flush_o         : bus64.flush_o;
      obs_rpc = (k == 0) ? {32'd0, bus32.redirect_pc_o} : bus64.redirect_pc_o;
      check({tag, ".resolve_valid"}, 64'(obs_rv), 64'(m_rv[k]));
      check({tag, ".br_taken"},      64'(obs_bt), 64'(m_bt[k]));
      check({tag, ".flush"},         64'(obs_fl), 64'(m_fl[k]));
      check({tag, ".redirect_pc"},   obs_rpc,     m_rpc[k]);
    end
  endtask

  task automatic idle(input int k, input logic [63:0] lpc, input string tag);
    step(k, 0, 0, 0, ALU, 3'd0, 0, 0, 0, 0, 0, 0, lpc, tag);
  endtask

  initial begin
    logic [6:0]  r_opc;
    logic [63:0] r_a, r_b, r_pc, r_imm, r_tgt;
    int          r_k, sel;
    rst_n = 1'b0;

    step(0, 1, 0, 0, ALU, 0, 0, 0, 0, 0, 0, 0, 0, "reset0");
    step(0, 1, 1, 0, BR,  0, 5, 5, 64'h100, 64'h20, 0, 0, 0, "reset1");
    step(1, 0, 0, 0, ALU, 0, 0, 0, 0, 0, 0, 0, 0, "after_reset64");

    step(0, 0, 1, 0, BR, 3'd0, 5, 5, 64'h100, 64'h20, 1, 64'h120, 64'h100, "beq_pred_ok");
    step(0, 0, 1, 0, BR, 3'd4, 64'hFFFF_FFFF, 1, 64'h200, 64'h40, 0, 0, 64'h200, "blt_signed");
    step(0, 0, 1, 0, BR, 3'd6, 64'hFFFF_FFFF, 1, 64'h200, 64'h40, 0, 0, 64'h200, "bltu");
    step(0, 0, 1, 0, BR, 3'd2, 7, 7, 64'h300, 64'h40, 0, 0, 64'h300, "undef_f3");
    step(0, 0, 1, 0, JALR, 3'd0, 64'h1003, 0, 64'h500, 64'h4, 1, 64'h1004, 64'h500, "jalr_mis");
    step(0, 0, 1, 0, JAL, 3'd0, 0, 0, 64'h600, 64'h80, 1, 64'h680, 64'h40, "jal_ok");

    for (int i = 0; i < 4; i++)
      step(0, 0, 1, 0, BR, 3'd1, 1, 2, 64'h40, 64'h10, 1, 64'h50, 64'h40, "bne_train_up");
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 0, BR, 3'd0, 1, 2, 64'h40, 64'h10, 0, 0, 64'h40, "beq_train_down");
    idle(0, 64'h40, "bht_after_down");

    idle(0, 0, "pre_stall");
    step(0, 0, 1, 1, BR, 3'd5, 5, 1, 64'h700, 64'h8, 0, 0, 64'h700, "bge_stalled");
    step(0, 0, 1, 0, BR, 3'd5, 5, 1, 64'h700, 64'h8, 0, 0, 64'h700, "bge_unstalled");
    idle(0, 64'h700, "bge_pulse_end");
    step(0, 0, 1, 0, BR, 3'd1, 1, 2, 64'h44, 64'h8, 0, 0, 64'h44, "b2b_a");
    step(0, 0, 1, 0, BR, 3'd1, 1, 2, 64'h44, 64'h8, 0, 0, 64'h44, "b2b_b");

    step(0, 0, 1, 0, BR, 3'd1, 1, 2, 64'h44, 64'h8, 0, 0, 64'h44, "train_to_sat");
    step(0, 1, 1, 0, BR, 3'd1, 1, 2, 64'h44, 64'h8, 0, 0, 64'h44, "reset_during_fire");
    idle(0, 64'h44, "lookup_after_reset");

    step(1, 0, 1, 0, BR, 3'd6, 64'h8000_0000_0000_0000, 1, 64'h1000, 64'h8, 0, 0, 64'h1000, "x64_bltu");
    step(1, 0, 1, 0, BR, 3'd0, 1, 2, 64'hFFFF_FFFF_FFFF_FFFC, 64'h10, 0, 0, 64'h1000, "x64_wrap");
    step(1, 0, 1, 0, BR, 3'd4, 64'h8000_0000_0000_0000, 1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 1,
         64'h10, 64'hFFFF_FFFF_FFFF_FFF0, "x64_blt_wrap");

    for (int i = 0; i < 300; i++) begin
      r_k   = int'($urandom_range(0, 1));
      sel   = int'($urandom_range(0, 9));
      r_opc = (sel < 6) ? BR : (sel == 6) ? JAL : (sel == 7) ? JALR : ALU;
      r_a   = {$urandom, $urandom};
      r_b   = ($urandom_range(0, 3) == 0) ? r_a : {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin r_a[63:4] = '0; r_b[63:4] = '0; end
      r_pc  = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
      if ($urandom_range(0, 1) == 1) r_pc = 64'(4 * $urandom_range(0, 31));
      r_imm = 64'(signed'(32'($urandom_range(0, 255) * 4) - 32'd512));
      r_tgt = ($urandom_range(0, 1) == 1) ? ((r_opc == JALR) ? ((r_a + r_imm) & ~64'd1) : (r_pc + r_imm))
                                          : {$urandom, $urandom};
      step(r_k, $urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
           r_opc, 3'($urandom_range(0, 7)), r_a, r_b, r_pc, r_imm, $urandom_range(0, 1) == 1,
           r_tgt, 64'(4 * $urandom_range(0, 31)), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
